// File: rtl/lift2_pkg.sv
// ============================================================================
// Module : lift2_pkg
// Brief  : Shared types and constants for the lift2 plant responder
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lift2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIRE = 2'd2
  } state_t;

  // Response patterns, bit n-1 drives sensor x<n>
  localparam logic [13:0] PAT_NONE = 14'h0000;
  localparam logic [13:0] PAT_X2X3 = 14'h0006;
  localparam logic [13:0] PAT_X5   = 14'h0010;
  localparam logic [13:0] PAT_X6   = 14'h0020;
  localparam logic [13:0] PAT_X7   = 14'h0040;
  localparam logic [13:0] PAT_X8   = 14'h0080;
  localparam logic [13:0] PAT_X10  = 14'h0200;
  localparam logic [13:0] PAT_X12  = 14'h0800;
  localparam logic [13:0] PAT_X13  = 14'h1000;

  typedef logic [3:0] entry_t;

  localparam entry_t ENT_NONE    = 4'd0;
  localparam entry_t ENT_TRAVEL2 = 4'd1;
  localparam entry_t ENT_Y14Y15  = 4'd2;
  localparam entry_t ENT_Y2Y3    = 4'd3;
  localparam entry_t ENT_Y2Y4    = 4'd4;
  localparam entry_t ENT_Y5Y7    = 4'd5;
  localparam entry_t ENT_Y6Y8    = 4'd6;
  localparam entry_t ENT_Y11Y13  = 4'd7;
  localparam entry_t ENT_Y1      = 4'd8;
  localparam entry_t ENT_TRAVEL1 = 4'd9;
  localparam entry_t ENT_Y16     = 4'd10;
  localparam entry_t ENT_Y9      = 4'd11;
  localparam entry_t ENT_Y10     = 4'd12;
  localparam entry_t ENT_Y12     = 4'd13;
  localparam entry_t ENT_Y6      = 4'd14;

  // Entries that are acknowledged without producing a response
  localparam logic [15:0] ACK_ONLY_MASK = 16'h4080;

endpackage

`default_nettype wire

// File: rtl/lift2_resp_decode.sv
// ============================================================================
// Module : lift2_resp_decode
// Brief  : Priority decoder from controller command bits to response entry
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lift2_resp_decode
  import lift2_pkg::*;
(
  input  logic [16:1] y_i,
  output logic        hit_o,
  output logic        ack_only_o,
  output logic [13:0] pattern_o,
  output logic        travel_o,
  output entry_t      entry_o
);

  entry_t      entry_w;
  logic [13:0] pat_w;
  logic        trav_w;

  // First match wins; unlisted bits are don't-care
  always_comb begin
    entry_w = ENT_NONE;
    pat_w   = PAT_NONE;
    trav_w  = 1'b0;
    if (y_i[3] & y_i[4] & y_i[14] & y_i[15]) begin
      entry_w = ENT_TRAVEL2; pat_w = PAT_X12; trav_w = 1'b1;
    end else if (y_i[14] & y_i[15]) begin
      entry_w = ENT_Y14Y15;  pat_w = PAT_X6;
    end else if (y_i[2] & y_i[3]) begin
      entry_w = ENT_Y2Y3;    pat_w = PAT_X5;
    end else if (y_i[2] & y_i[4]) begin
      entry_w = ENT_Y2Y4;    pat_w = PAT_X2X3;
    end else if (y_i[5] & y_i[7]) begin
      entry_w = ENT_Y5Y7;    pat_w = PAT_X6;
    end else if (y_i[6] & y_i[8]) begin
      entry_w = ENT_Y6Y8;    pat_w = PAT_X6;
    end else if (y_i[11] & y_i[13]) begin
      entry_w = ENT_Y11Y13;
    end else if (y_i[1]) begin
      entry_w = ENT_Y1;      pat_w = PAT_X2X3;
    end else if (y_i[3] | y_i[4]) begin
      entry_w = ENT_TRAVEL1; pat_w = PAT_X12; trav_w = 1'b1;
    end else if (y_i[16]) begin
      entry_w = ENT_Y16;     pat_w = PAT_X13;
    end else if (y_i[9]) begin
      entry_w = ENT_Y9;      pat_w = PAT_X7;
    end else if (y_i[10]) begin
      entry_w = ENT_Y10;     pat_w = PAT_X8;
    end else if (y_i[12]) begin
      entry_w = ENT_Y12;     pat_w = PAT_X10;
    end else if (y_i[6]) begin
      entry_w = ENT_Y6;
    end
  end

  assign hit_o      = (entry_w != ENT_NONE);
  assign ack_only_o = ACK_ONLY_MASK[entry_w];
  assign pattern_o  = pat_w;
  assign travel_o   = trav_w;
  assign entry_o    = entry_w;

endmodule

`default_nettype wire

// File: rtl/lift2_plant_resp.sv
// ============================================================================
// Module : lift2_plant_resp
// Brief  : Plant-side responder: delayed one-cycle sensor pulses per command
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lift2_plant_resp
  import lift2_pkg::*;
#(
  parameter int LAT        = 3,
  parameter int TRAVEL_LAT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic y1,  input logic y2,  input logic y3,  input logic y4,
  input  logic y5,  input logic y6,  input logic y7,  input logic y8,
  input  logic y9,  input logic y10, input logic y11, input logic y12,
  input  logic y13, input logic y14, input logic y15, input logic y16,
  input  logic call_req,
  input  logic park_req,
  input  logic dir_sel,
  output logic x1,  output logic x2,  output logic x3,  output logic x4,
  output logic x5,  output logic x6,  output logic x7,  output logic x8,
  output logic x9,  output logic x10, output logic x11, output logic x12,
  output logic x13, output logic x14,
  output logic busy,
  output logic err
);

  localparam int MAX_LAT = (LAT > TRAVEL_LAT) ? LAT : TRAVEL_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] LAT_C    = CW'(LAT);
  localparam logic [CW-1:0] TRAVEL_C = CW'(TRAVEL_LAT);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic [16:1] cmd_w;
  logic        cmd_any_w;
  logic        hit_w;
  logic        ack_w;
  logic [13:0] pat_w;
  logic        travel_w;
  entry_t      entry_w;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [13:0]   pat_q, pat_d;
  logic          err_q, err_d;
  logic          call_q, call_d;
  logic          park_q, park_d;
  logic [13:0]   x_q, x_d;
  logic          capture_w;

  assign cmd_w = {y16, y15, y14, y13, y12, y11, y10, y9,
                  y8,  y7,  y6,  y5,  y4,  y3,  y2,  y1};
  assign cmd_any_w = |cmd_w;

  lift2_resp_decode u_decode (
    .y_i        (cmd_w),
    .hit_o      (hit_w),
    .ack_only_o (ack_w),
    .pattern_o  (pat_w),
    .travel_o   (travel_w),
    .entry_o    (entry_w)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    err_d     = err_q;
    capture_w = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_any_w) begin
          if (!hit_w) begin
            err_d = 1'b1;
          end else begin
            capture_w = 1'b1;
            if (!ack_w) begin
              pat_d   = pat_w;
              cnt_d   = travel_w ? TRAVEL_C : LAT_C;
              state_d = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        // Commands arriving while busy are dropped, timing is untouched
        if (cmd_any_w) err_d = 1'b1;
        if (cnt_q == ONE_C) begin
          state_d = ST_FIRE;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      ST_FIRE: begin
        if (cmd_any_w) err_d = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Set beats clear when both land on the same edge
    call_d = call_req | (call_q & ~(capture_w && (entry_w == ENT_Y1)));
    park_d = park_req | (park_q & ~(capture_w &&
             ((entry_w == ENT_Y6Y8) || (entry_w == ENT_Y6))));

    x_d     = (state_d == ST_FIRE) ? pat_q : PAT_NONE;
    x_d[0]  = call_d;
    x_d[3]  = dir_sel;
    x_d[10] = park_d;
    x_d[8]  = 1'b0;
    x_d[13] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      err_q   <= 1'b0;
      call_q  <= 1'b0;
      park_q  <= 1'b0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      err_q   <= err_d;
      call_q  <= call_d;
      park_q  <= park_d;
      x_q     <= x_d;
    end
  end

  assign {x14, x13, x12, x11, x10, x9, x8, x7, x6, x5, x4, x3, x2, x1} = x_q;
  assign busy = (state_q != ST_IDLE);
  assign err  = err_q;

endmodule

`default_nettype wire
